decode_session_scheduler: RTL
=============================

Name: decode_session_scheduler

Overview:
- Hardware host-side sequencer for the single-FPGA Helios decoder byte interface.
- Sends the start-decoding message once after reset.
- Per syndrome block: sends the measurement header and serialises one captured measurement block into 8-bit valid/ready bytes.
- Collects the decoder's response (iteration count, 16-bit cycle count) and presents it as one result record with timeout/framing flags.

Parameters:
GRID_WIDTH_X, 8, X extent of the PU grid (d+1)
GRID_WIDTH_Z, 3, Z extent of the PU grid ((X-1)/2)
GRID_WIDTH_U, 7, measurement rounds
TIMEOUT_CYCLES, 65535, max idle cycles waiting for a response byte; width = $clog2(TIMEOUT_CYCLES+1)
Derived: BYTES_PER_ROUND = (X*Z+7)>>3; TOTAL_BYTES = BYTES_PER_ROUND*U; MEAS_WIDTH = TOTAL_BYTES*8

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset (0 = reset)
meas_data  in  MEAS_WIDTH  round-padded measurement block, round k at bits [k*BYTES_PER_ROUND*8 +: BYTES_PER_ROUND*8]
meas_valid  in  1  block available
meas_ready  out  1  block accepted when meas_valid & meas_ready
dec_in_data  out  8  byte to decoder
dec_in_valid  out  1  byte valid
dec_in_ready  in  1  decoder accepts byte
dec_out_data  in  8  response byte from decoder
dec_out_valid  in  1  response byte valid
dec_out_ready  out  1  scheduler accepts response byte
res_iterations  out  8  captured iteration count
res_cycles  out  16  captured cycle count
res_timeout  out  1  no response byte within TIMEOUT_CYCLES
res_short  out  1  response held fewer than 3 bytes
res_long  out  1  response held more than 3 bytes (extras discarded)
res_valid  out  1  result record valid
res_ready  in  1  result consumer ready
busy  out  1  state is not WAIT_MEAS
session_count  out  32  completed sessions, wraps at 2^32

Behaviour:
- Reset (reset=0, async): state=SEND_START; all outputs 0; meas_buf, byte_idx, timer and result registers cleared.
- SEND_START: dec_in_valid=1, dec_in_data=START_DECODING_MSG. On dec_in_ready -> WAIT_MEAS. Never re-entered except via reset.
- WAIT_MEAS: meas_ready=1. On handshake: meas_buf<=meas_data, byte_idx<=0 -> SEND_HDR. The header is valid on the cycle after capture.
- SEND_HDR: dec_in_valid=1, data=MEASUREMENT_DATA_HEADER. On ready -> SEND_DATA.
- SEND_DATA: dec_in_valid=1, data=meas_buf[byte_idx*8 +: 8].
  - byte_idx advances only on ready.
  - On ready with byte_idx==TOTAL_BYTES-1: timer<=0 -> WAIT_RESP.
  - Data and valid stay stable while ready=0.
- WAIT_RESP: dec_out_ready=1.
  - Byte accepted: resp_cnt<=1, store byte as iterations -> RECV_RESP.
  - Otherwise timer increments; at timer==TIMEOUT_CYCLES-1 with no byte: timeout=1, iterations=0, cycles=0 -> EMIT.
- RECV_RESP: dec_out_ready=1.
  - Each accepted byte: resp_cnt+1 (saturates at 4). Byte index 1 -> cycles[15:8]; index 2 -> cycles[7:0]; index>=3 discarded, long=1.
  - First cycle with dec_out_valid=0: short=(resp_cnt<3) -> EMIT.
- EMIT: res_valid=1; all res_* held stable. On res_ready: session_count+1, flags cleared -> WAIT_MEAS.
- dec_out_ready=0 outside WAIT_RESP/RECV_RESP. Response bytes arriving in other states are back-pressured, never dropped.
- meas_ready=0 outside WAIT_MEAS, so at most one block is in flight.
- Simultaneous dec_in and dec_out activity cannot occur (mutually exclusive states).
- Reset mid-session abandons the session; after reset the scheduler re-sends START_DECODING_MSG.
- Unused padding bits of meas_data are transmitted as given (bench drives 0).

Decomposition:
- Shared package (with existing message constants): START_DECODING_MSG, MEASUREMENT_DATA_HEADER, state enum sched_state_t {SEND_START, WAIT_MEAS, SEND_HDR, SEND_DATA, WAIT_RESP, RECV_RESP, EMIT}, function bytes_per_round(x,z).
- One natural sub-module: meas_byte_serializer (buffer + byte_idx + last flag, valid/ready out). The FSM stays in the top.

Test Plan:
1. Reset release with dec_in_ready=1 -> exactly one START_DECODING_MSG byte, then meas_ready=1, busy=0.
2. d=7 block with byte n = n (n=0..20), dec_in_ready=1 -> header, then 21 bytes 0x00..0x14 in order; dec_out_ready=1 the cycle after the last byte.
3. dec_in_ready toggling 1,0,0,1 during SEND_DATA -> dec_in_data stable while stalled; no byte duplicated or skipped.
4. Response 0x05,0x01,0x2C then valid low, res_ready=1 -> res_iterations=5, res_cycles=300, flags 0, session_count=1.
5. Response 0x03 only -> res_short=1, res_cycles=0. Response of 5 bytes -> res_long=1 and the first 3 bytes decoded.
6. TIMEOUT_CYCLES=16, decoder silent -> res_valid after 16 WAIT_RESP cycles with res_timeout=1. Then assert reset during SEND_DATA -> START_DECODING_MSG re-sent, session_count=0.

Source files
------------

// File: rtl/decode_session_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// decode_session_scheduler_pkg
// Shared definitions for the Helios host-side decode session sequencer:
//   - decoder byte-protocol message constants
//   - scheduler state encoding
//   - measurement block sizing helper
// -----------------------------------------------------------------------------
package decode_session_scheduler_pkg;

   localparam logic [7:0] START_DECODING_MSG      = 8'h01;
   localparam logic [7:0] MEASUREMENT_DATA_HEADER = 8'h02;

   typedef enum logic [2:0] {
      SEND_START,
      WAIT_MEAS,
      SEND_HDR,
      SEND_DATA,
      WAIT_RESP,
      RECV_RESP,
      EMIT
   } sched_state_t;

   // Bytes needed for one measurement round of an x-by-z PU grid.
   function automatic int unsigned bytes_per_round(input int unsigned x,
                                                   input int unsigned z);
      return (x * z + 7) >> 3;
   endfunction

endpackage

// File: rtl/meas_byte_serializer.sv
// -----------------------------------------------------------------------------
// meas_byte_serializer
// Holds one captured measurement block and presents it LSB byte first as a
// valid/ready byte stream.
// Ports:
//   clk, reset        clock, asynchronous active-low reset
//   load, load_data   capture a new block and rewind to byte 0
//   start             begin presenting bytes (valid rises next cycle)
//   out_data/valid    current byte and its valid flag
//   out_ready         consumer accepts the current byte
//   out_last          current byte is the final byte of the block
// -----------------------------------------------------------------------------
module meas_byte_serializer
   import decode_session_scheduler_pkg::*;
#(
   parameter int unsigned TOTAL_BYTES = 21
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     load,
   input  logic [TOTAL_BYTES*8-1:0] load_data,
   input  logic                     start,
   output logic [7:0]               out_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic                     out_last
);

   localparam int unsigned IW = (TOTAL_BYTES > 1) ? $clog2(TOTAL_BYTES) : 1;

   logic [TOTAL_BYTES*8-1:0] data_q;
   logic [IW-1:0]            idx_q;
   logic                     active_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         data_q   <= '0;
         idx_q    <= '0;
         active_q <= 1'b0;
      end else begin
         if (load) begin
            data_q <= load_data;
            idx_q  <= '0;
         end
         if (start) begin
            active_q <= 1'b1;
         end else if (active_q && out_ready) begin
            if (out_last) begin
               active_q <= 1'b0;
            end else begin
               idx_q <= idx_q + 1'b1;
            end
         end
      end
   end

   // Byte select as a shift keeps the index arithmetic width-clean.
   assign out_data  = 8'(data_q >> {idx_q, 3'b000});
   assign out_valid = active_q;
   assign out_last  = (idx_q == IW'(TOTAL_BYTES - 1));

endmodule

// File: rtl/decode_session_scheduler.sv
// -----------------------------------------------------------------------------
// decode_session_scheduler
// Host-side sequencer for the Helios decoder byte interface. Sends the
// start-decoding message once after reset, then per measurement block sends
// the header plus the serialised block, collects the 3-byte response
// (iterations, cycles[15:8], cycles[7:0]) and presents it as a result record.
// Ports:
//   clk, reset                       clock, asynchronous active-low reset
//   meas_data/valid/ready            measurement block input handshake
//   dec_in_data/valid/ready          byte stream to the decoder
//   dec_out_data/valid/ready         response bytes from the decoder
//   res_iterations, res_cycles       decoded response fields
//   res_timeout, res_short, res_long response status flags
//   res_valid/ready                  result record handshake
//   busy                             scheduler not idle in WAIT_MEAS
//   session_count                    completed sessions (wraps)
// -----------------------------------------------------------------------------
module decode_session_scheduler
   import decode_session_scheduler_pkg::*;
#(
   parameter int unsigned GRID_WIDTH_X   = 8,
   parameter int unsigned GRID_WIDTH_Z   = 3,
   parameter int unsigned GRID_WIDTH_U   = 7,
   parameter int unsigned TIMEOUT_CYCLES = 65535
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [bytes_per_round(GRID_WIDTH_X, GRID_WIDTH_Z)*GRID_WIDTH_U*8-1:0] meas_data,
   input  logic        meas_valid,
   output logic        meas_ready,
   output logic [7:0]  dec_in_data,
   output logic        dec_in_valid,
   input  logic        dec_in_ready,
   input  logic [7:0]  dec_out_data,
   input  logic        dec_out_valid,
   output logic        dec_out_ready,
   output logic [7:0]  res_iterations,
   output logic [15:0] res_cycles,
   output logic        res_timeout,
   output logic        res_short,
   output logic        res_long,
   output logic        res_valid,
   input  logic        res_ready,
   output logic        busy,
   output logic [31:0] session_count
);

   localparam int unsigned BYTES_PER_ROUND = bytes_per_round(GRID_WIDTH_X, GRID_WIDTH_Z);
   localparam int unsigned TOTAL_BYTES     = BYTES_PER_ROUND * GRID_WIDTH_U;
   localparam int unsigned TW              = $clog2(TIMEOUT_CYCLES + 1);

   sched_state_t state_q;
   logic         msg_valid_q;
   logic [7:0]   msg_data_q;
   logic         meas_ready_q;
   logic         dec_out_ready_q;
   logic         res_valid_q;
   logic         busy_q;
   logic [TW-1:0] timer_q;
   logic [2:0]   resp_cnt_q;
   logic [7:0]   iterations_q;
   logic [15:0]  cycles_q;
   logic         timeout_q;
   logic         short_q;
   logic         long_q;
   logic [31:0]  session_q;

   logic         meas_hs;
   logic         msg_hs;
   logic         resp_hs;
   logic         ser_start;
   logic [7:0]   ser_data;
   logic         ser_valid;
   logic         ser_last;
   logic         ser_done;

   assign meas_hs   = meas_valid & meas_ready_q;
   assign msg_hs    = msg_valid_q & dec_in_ready;
   assign resp_hs   = dec_out_valid & dec_out_ready_q;
   assign ser_start = (state_q == SEND_HDR) & msg_hs;
   assign ser_done  = ser_valid & dec_in_ready & ser_last;

   meas_byte_serializer #(
      .TOTAL_BYTES (TOTAL_BYTES)
   ) u_serializer (
      .clk       (clk),
      .reset     (reset),
      .load      (meas_hs),
      .load_data (meas_data),
      .start     (ser_start),
      .out_data  (ser_data),
      .out_valid (ser_valid),
      .out_ready (dec_in_ready),
      .out_last  (ser_last)
   );

   // Message bytes (start/header) and data bytes never overlap in time, so
   // the decoder port is a simple merge of the two registered sources.
   assign dec_in_valid = msg_valid_q | ser_valid;
   assign dec_in_data  = ser_valid ? ser_data : msg_data_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q         <= SEND_START;
         msg_valid_q     <= 1'b0;
         msg_data_q      <= '0;
         meas_ready_q    <= 1'b0;
         dec_out_ready_q <= 1'b0;
         res_valid_q     <= 1'b0;
         busy_q          <= 1'b0;
         timer_q         <= '0;
         resp_cnt_q      <= '0;
         iterations_q    <= '0;
         cycles_q        <= '0;
         timeout_q       <= 1'b0;
         short_q         <= 1'b0;
         long_q          <= 1'b0;
         session_q       <= '0;
      end else begin
         case (state_q)
            SEND_START: begin
               busy_q <= 1'b1;
               if (!msg_valid_q) begin
                  msg_valid_q <= 1'b1;
                  msg_data_q  <= START_DECODING_MSG;
               end else if (dec_in_ready) begin
                  msg_valid_q  <= 1'b0;
                  meas_ready_q <= 1'b1;
                  busy_q       <= 1'b0;
                  state_q      <= WAIT_MEAS;
               end
            end
            WAIT_MEAS: begin
               if (meas_hs) begin
                  meas_ready_q <= 1'b0;
                  busy_q       <= 1'b1;
                  msg_valid_q  <= 1'b1;
                  msg_data_q   <= MEASUREMENT_DATA_HEADER;
                  state_q      <= SEND_HDR;
               end
            end
            SEND_HDR: begin
               if (msg_hs) begin
                  msg_valid_q <= 1'b0;
                  state_q     <= SEND_DATA;
               end
            end
            SEND_DATA: begin
               if (ser_done) begin
                  timer_q         <= '0;
                  dec_out_ready_q <= 1'b1;
                  state_q         <= WAIT_RESP;
               end
            end
            WAIT_RESP: begin
               if (resp_hs) begin
                  resp_cnt_q   <= 3'd1;
                  iterations_q <= dec_out_data;
                  cycles_q     <= '0;
                  state_q      <= RECV_RESP;
               end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
                  timeout_q       <= 1'b1;
                  iterations_q    <= '0;
                  cycles_q        <= '0;
                  dec_out_ready_q <= 1'b0;
                  res_valid_q     <= 1'b1;
                  state_q         <= EMIT;
               end else begin
                  timer_q <= timer_q + 1'b1;
               end
            end
            RECV_RESP: begin
               if (resp_hs) begin
                  case (resp_cnt_q)
                     3'd1:    cycles_q[15:8] <= dec_out_data;
                     3'd2:    cycles_q[7:0]  <= dec_out_data;
                     default: long_q         <= 1'b1;
                  endcase
                  if (resp_cnt_q != 3'd4) begin
                     resp_cnt_q <= resp_cnt_q + 3'd1;
                  end
               end else begin
                  short_q         <= (resp_cnt_q < 3'd3);
                  dec_out_ready_q <= 1'b0;
                  res_valid_q     <= 1'b1;
                  state_q         <= EMIT;
               end
            end
            EMIT: begin
               if (res_ready) begin
                  res_valid_q  <= 1'b0;
                  session_q    <= session_q + 32'd1;
                  timeout_q    <= 1'b0;
                  short_q      <= 1'b0;
                  long_q       <= 1'b0;
                  meas_ready_q <= 1'b1;
                  busy_q       <= 1'b0;
                  state_q      <= WAIT_MEAS;
               end
            end
            default: state_q <= SEND_START;
         endcase
      end
   end

   assign meas_ready     = meas_ready_q;
   assign dec_out_ready  = dec_out_ready_q;
   assign res_iterations = iterations_q;
   assign res_cycles     = cycles_q;
   assign res_timeout    = timeout_q;
   assign res_short      = short_q;
   assign res_long       = long_q;
   assign res_valid      = res_valid_q;
   assign busy           = busy_q;
   assign session_count  = session_q;

endmodule
